// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and width limits for piso_serializer
// State PARITY is only reachable when PISO_SER_PARITY_EN is defined.
package piso_pkg;

  localparam int MIN_WIDTH = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t PARITY = 2'd2;

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - per-frame bit counter for piso_serializer
// last flags the cycle in which the WIDTH-th data bit is on the output.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  // Saturates at WIDTH so the count can never wrap inside a frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(WIDTH))) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with ready/valid load
// Define PISO_SER_PARITY_EN to append one even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             last;
  logic             accept;
  logic             in_shift;
  logic             cnt_clear;

  assign in_shift = (state == SHIFT);

`ifdef PISO_SER_PARITY_EN
  logic parity;
  assign done = (state == PARITY);
`else
  assign done = in_shift && last;
`endif

  // Ready on the final bit as well as in IDLE, so frames can run back to back.
  assign load_ready   = (state == IDLE) || done;
  assign accept       = load_valid && load_ready;
  assign busy         = (state != IDLE);
  assign serial_valid = busy;
  assign cnt_clear    = accept || !in_shift;

  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], shift_in}
                             : {shift_in, shreg[WIDTH-1:1]};

  always_comb begin
    serial_out = 1'b0;
    if (in_shift) begin
      serial_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
`ifdef PISO_SER_PARITY_EN
    else if (state == PARITY) begin
      serial_out = parity;
    end
`endif
  end

  piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (in_shift),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
`ifdef PISO_SER_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      shreg <= parallel_in;
`ifdef PISO_SER_PARITY_EN
      parity <= ^parallel_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shreg <= shifted;
          if (last) begin
`ifdef PISO_SER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer, both bit orders
// Honours PISO_SER_PARITY_EN when expecting the frame contents.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] parallel_in;
  logic         shift_in;

  logic lr_m, so_m, sv_m, busy_m, done_m;
  logic lr_l, so_l, sv_l, busy_l, done_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected remaining serial bits of the frame in flight, front = bit on the wire now.
  bit q_m[$];
  bit q_l[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (lr_m),
    .parallel_in  (parallel_in),
    .shift_in     (shift_in),
    .serial_out   (so_m),
    .serial_valid (sv_m),
    .busy         (busy_m),
    .done         (done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (lr_l),
    .parallel_in  (parallel_in),
    .shift_in     (shift_in),
    .serial_out   (so_l),
    .serial_valid (sv_l),
    .busy         (busy_l),
    .done         (done_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic lr, input logic so, input logic sv,
                           input logic bz, input logic dn, input int sz, input bit front);
    chk({nm, ".load_ready"},   lr, sz <= 1);
    chk({nm, ".serial_valid"}, sv, sz != 0);
    chk({nm, ".serial_out"},   so, (sz != 0) ? front : 1'b0);
    chk({nm, ".busy"},         bz, sz != 0);
    chk({nm, ".done"},         dn, sz == 1);
  endtask

  // One clock: drive inputs, check the current cycle, advance the model across the edge.
  task automatic step(input bit lv, input logic [W-1:0] w, input bit r);
    bit acc_m, acc_l;
    load_valid  = lv;
    parallel_in = w;
    rst         = r;
    shift_in    = 1'($urandom);
    #1;
    check_dut("msb", lr_m, so_m, sv_m, busy_m, done_m, q_m.size(), (q_m.size() != 0) ? q_m[0] : 1'b0);
    check_dut("lsb", lr_l, so_l, sv_l, busy_l, done_l, q_l.size(), (q_l.size() != 0) ? q_l[0] : 1'b0);
    acc_m = lv && !r && (q_m.size() <= 1);
    acc_l = lv && !r && (q_l.size() <= 1);
    @(posedge clk);
    #1;
    if (r) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (q_l.size() != 0) void'(q_l.pop_front());
      if (acc_m) begin
        for (int i = W - 1; i >= 0; i--) q_m.push_back(w[i]);
`ifdef PISO_SER_PARITY_EN
        q_m.push_back(^w);
`endif
      end
      if (acc_l) begin
        for (int i = 0; i < W; i++) q_l.push_back(w[i]);
`ifdef PISO_SER_PARITY_EN
        q_l.push_back(^w);
`endif
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    load_valid  = 1'b0;
    parallel_in = '0;
    shift_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with rst dominating a live load request.
    step(1'b1, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b0);

    // Single frame 1011, then idle.
    step(1'b1, 4'b1011, 1'b0);
    repeat (W + 2) step(1'b0, 4'($urandom), 1'b0);

    // Back to back: 1011 then 0110 with load_valid held high throughout.
    step(1'b1, 4'b1011, 1'b0);
    repeat (W + 1) step(1'b1, 4'b0110, 1'b0);
    repeat (W + 2) step(1'b0, 4'b0000, 1'b0);

    // Reset on the second bit of 1111 aborts the frame.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 1'b0);

    // A load pulse mid-frame is ignored.
    step(1'b1, 4'b1011, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    repeat (W + 1) step(1'b0, 4'b0101, 1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 39) == 0));
    end
    repeat (W + 2) step(1'b0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
